// File: rtl/vending_lcd_text_composer.sv
// Composes two 16-char LCD lines and a cursor address from vending state (item, price, balance, admin flag).
// Latency: update sampled at edge T -> text committed with a one-cycle text_valid pulse at edge T+2*BIN_W+2.
// Backpressure: none; an update while busy sets a pending flag, and all such requests coalesce into one re-run.
//
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits of price/balance).
// Ports: clk, rst (sync, active-low), update, admin_mode, item_idx[3:0], price/balance[BIN_W-1:0]
//        -> line1_text/line2_text[127:0] (char 0 in [127:120]), ddram_address[6:0], busy, text_valid.
module vending_lcd_text_composer #(
    parameter int BIN_W   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             update,
    input  logic             admin_mode,
    input  logic [3:0]       item_idx,
    input  logic [BIN_W-1:0] price,
    input  logic [BIN_W-1:0] balance,
    output logic [127:0]     line1_text,
    output logic [127:0]     line2_text,
    output logic [6:0]       ddram_address,
    output logic             busy,
    output logic             text_valid
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_CONV_PRICE = 3'd1;
    localparam logic [2:0] ST_CONV_BAL   = 3'd2;
    localparam logic [2:0] ST_ASSEMBLE   = 3'd3;
    localparam logic [2:0] ST_COMMIT     = 3'd4;

    localparam int CNT_W = $clog2(BIN_W);

    localparam logic [127:0] ALL_SPACES = {16{8'h20}};
    localparam logic [39:0]  TXT_ITEM   = "ITEM:";
    localparam logic [23:0]  TXT_P      = " P:";
    localparam logic [23:0]  TXT_SP3    = "   ";
    localparam logic [47:0]  TXT_MONEY  = "MONEY:";
    localparam logic [47:0]  TXT_SP6    = "      ";
    localparam logic [79:0]  TXT_ADMIN  = "ADMIN MODE";

    logic [2:0]       state;
    logic             pending;
    logic             sh_admin;
    logic [3:0]       sh_item;
    logic [BIN_W-1:0] sh_bal;
    logic             ovf_price;
    logic             ovf_bal;
    logic [BIN_W-1:0] work;       // value being shifted out MSB-first
    logic [15:0]      bcd;        // four-digit double-dabble accumulator
    logic [15:0]      bcd_next;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      price_bcd;
    logic [15:0]      bal_bcd;
    logic [127:0]     stg_l1;
    logic [127:0]     stg_l2;
    logic [6:0]       stg_addr;
    logic             start;
    logic             last_shift;

    function automatic logic over_max(input logic [BIN_W-1:0] v);
        return ({{(32-BIN_W){1'b0}}, v} > 32'(MAX_VAL));
    endfunction

    // One double-dabble step: correct nibbles >= 5, then shift in the next binary bit.
    function automatic logic [15:0] dd_step(input logic [15:0] b, input logic in_bit);
        logic [15:0] a;
        a = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                a[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return {a[14:0], in_bit};
    endfunction

    // Four ASCII characters for a BCD value; overflow wins over the digits.
    function automatic logic [31:0] render4(input logic [15:0] b, input logic ovf);
        logic [31:0] s;
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
`endif
        for (int i = 0; i < 4; i++) begin
            s[8*i +: 8] = 8'h30 + {4'h0, b[4*i +: 4]};
        end
`ifdef LEADING_ZERO_BLANK_EN
        // Units digit (i = 0) always shows, so zero renders as "   0".
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (lead && (b[4*i +: 4] == 4'd0)) begin
                s[8*i +: 8] = 8'h20;
            end else begin
                lead = 1'b0;
            end
        end
`endif
        if (ovf) begin
            s = 32'h2D2D_2D2D;
        end
        return s;
    endfunction

    assign bcd_next   = dd_step(bcd, work[BIN_W-1]);
    assign last_shift = (cnt == CNT_W'(BIN_W - 1));
    // A request seen during COMMIT re-runs immediately instead of dropping to IDLE.
    assign start      = ((state == ST_IDLE) && update) ||
                        ((state == ST_COMMIT) && (pending || update));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            pending       <= 1'b0;
            sh_admin      <= 1'b0;
            sh_item       <= 4'd0;
            sh_bal        <= '0;
            ovf_price     <= 1'b0;
            ovf_bal       <= 1'b0;
            work          <= '0;
            bcd           <= 16'd0;
            cnt           <= '0;
            price_bcd     <= 16'd0;
            bal_bcd       <= 16'd0;
            stg_l1        <= ALL_SPACES;
            stg_l2        <= ALL_SPACES;
            stg_addr      <= 7'd0;
            line1_text    <= ALL_SPACES;
            line2_text    <= ALL_SPACES;
            ddram_address <= 7'd0;
            busy          <= 1'b0;
            text_valid    <= 1'b0;
        end else begin
            text_valid <= 1'b0;

            if (state == ST_COMMIT) begin
                line1_text    <= stg_l1;
                line2_text    <= stg_l2;
                ddram_address <= stg_addr;
                text_valid    <= 1'b1;
            end

            if (start) begin
                sh_admin  <= admin_mode;
                sh_item   <= item_idx;
                sh_bal    <= balance;
                ovf_price <= over_max(price);
                ovf_bal   <= over_max(balance);
                work      <= price;
                bcd       <= 16'd0;
                cnt       <= '0;
                pending   <= 1'b0;
                busy      <= 1'b1;
                state     <= ST_CONV_PRICE;
            end else begin
                if ((state != ST_IDLE) && update) begin
                    pending <= 1'b1;
                end
                case (state)
                    ST_CONV_PRICE: begin
                        bcd  <= bcd_next;
                        work <= work << 1;
                        cnt  <= cnt + 1'b1;
                        if (last_shift) begin
                            price_bcd <= bcd_next;
                            bcd       <= 16'd0;
                            cnt       <= '0;
                            work      <= sh_bal;
                            state     <= ST_CONV_BAL;
                        end
                    end
                    ST_CONV_BAL: begin
                        bcd  <= bcd_next;
                        work <= work << 1;
                        cnt  <= cnt + 1'b1;
                        if (last_shift) begin
                            bal_bcd <= bcd_next;
                            bcd     <= 16'd0;
                            cnt     <= '0;
                            state   <= ST_ASSEMBLE;
                        end
                    end
                    ST_ASSEMBLE: begin
                        stg_l1 <= {TXT_ITEM,
                                   (sh_item > 4'd9) ? 8'h3F : (8'h30 + {4'h0, sh_item}),
                                   TXT_P, render4(price_bcd, ovf_price), TXT_SP3};
                        if (sh_admin) begin
                            stg_l2   <= {TXT_ADMIN, TXT_SP6};
                            stg_addr <= 7'h40;
                        end else begin
                            stg_l2   <= {TXT_MONEY, render4(bal_bcd, ovf_bal), TXT_SP6};
                            stg_addr <= 7'h05;
                        end
                        state <= ST_COMMIT;
                    end
                    ST_COMMIT: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vending_lcd_text_composer.sv
module tb_vending_lcd_text_composer;

    localparam int BIN_W = 14;
    localparam int LAT   = 2 * BIN_W + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             update;
    logic             admin_mode;
    logic [3:0]       item_idx;
    logic [BIN_W-1:0] price;
    logic [BIN_W-1:0] balance;
    logic [127:0]     line1_text;
    logic [127:0]     line2_text;
    logic [6:0]       ddram_address;
    logic             busy;
    logic             text_valid;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] SPACES = {16{8'h20}};

    vending_lcd_text_composer #(.BIN_W(BIN_W), .MAX_VAL(9999)) dut (
        .clk           (clk),
        .rst           (rst),
        .update        (update),
        .admin_mode    (admin_mode),
        .item_idx      (item_idx),
        .price         (price),
        .balance       (balance),
        .line1_text    (line1_text),
        .line2_text    (line2_text),
        .ddram_address (ddram_address),
        .busy          (busy),
        .text_valid    (text_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference rendering from decimal arithmetic on the plain integer value.
    function automatic logic [31:0] m_fmt(input int v);
        logic [31:0] s;
        if (v > 9999) return 32'h2D2D_2D2D;
        s = {8'h30 + 8'(v / 1000), 8'h30 + 8'((v / 100) % 10),
             8'h30 + 8'((v / 10) % 10), 8'h30 + 8'(v % 10)};
`ifdef LEADING_ZERO_BLANK_EN
        if (v < 1000) s[31:24] = 8'h20;
        if (v < 100)  s[23:16] = 8'h20;
        if (v < 10)   s[15:8]  = 8'h20;
`endif
        return s;
    endfunction

    function automatic logic [127:0] m_l1(input int item, input int pr);
        logic [39:0] a;
        logic [23:0] b;
        logic [23:0] c;
        logic [7:0]  d;
        a = "ITEM:";
        b = " P:";
        c = "   ";
        d = (item > 9) ? 8'h3F : 8'(8'h30 + item);
        return {a, d, b, m_fmt(pr), c};
    endfunction

    function automatic logic [127:0] m_l2(input bit adm, input int bl);
        logic [47:0] m;
        logic [47:0] sp;
        logic [79:0] ad;
        m  = "MONEY:";
        sp = "      ";
        ad = "ADMIN MODE";
        if (adm) return {ad, sp};
        return {m, m_fmt(bl), sp};
    endfunction

    task automatic set_inputs(input int it, input int pr, input int bl, input bit adm);
        item_idx   = 4'(it);
        price      = BIN_W'(pr);
        balance    = BIN_W'(bl);
        admin_mode = adm;
    endtask

    // Update is sampled on the posedge between these two negedges.
    task automatic pulse_update;
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic run_txn(input string tag, input int it, input int pr, input int bl, input bit adm,
                           input logic [127:0] e1, input logic [127:0] e2, input logic [6:0] ea);
        logic [127:0] old1;
        logic [127:0] old2;
        set_inputs(it, pr, bl, adm);
        old1 = line1_text;
        old2 = line2_text;
        pulse_update();
        chk({tag, ":busy_start"}, 128'(busy), 128'(1));
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            chk({tag, ":tv_early"}, 128'(text_valid), 128'(0));
            chk({tag, ":busy_mid"}, 128'(busy), 128'(1));
            if (k == LAT / 2) chk({tag, ":hold_l1"}, line1_text, old1);
            if (k == LAT / 2) chk({tag, ":hold_l2"}, line2_text, old2);
        end
        @(negedge clk);
        chk({tag, ":tv"}, 128'(text_valid), 128'(1));
        chk({tag, ":l1"}, line1_text, e1);
        chk({tag, ":l2"}, line2_text, e2);
        chk({tag, ":addr"}, 128'(ddram_address), 128'(ea));
        chk({tag, ":busy_end"}, 128'(busy), 128'(0));
        @(negedge clk);
        chk({tag, ":tv_once"}, 128'(text_valid), 128'(0));
        chk({tag, ":l1_held"}, line1_text, e1);
    endtask

    task automatic run_model(input string tag, input int it, input int pr, input int bl, input bit adm);
        run_txn(tag, it, pr, bl, adm, m_l1(it, pr), m_l2(adm, bl), adm ? 7'h40 : 7'h05);
    endtask

    logic [127:0] exp1;
    logic [127:0] exp2;
    int           tv_cnt;
    int           r_it;
    int           r_pr;
    int           r_bl;
    bit           r_adm;

    initial begin
        rst    = 1'b0;
        update = 1'b0;
        set_inputs(0, 0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_l1", line1_text, SPACES);
        chk("rst_l2", line2_text, SPACES);
        chk("rst_addr", 128'(ddram_address), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_tv", 128'(text_valid), 128'(0));
        rst = 1'b1;

        // Idle for 40 cycles: nothing may change.
        tv_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (text_valid !== 1'b0 || busy !== 1'b0) tv_cnt++;
        end
        chk("idle_quiet", 128'(tv_cnt), 128'(0));
        chk("idle_l1", line1_text, SPACES);
        chk("idle_l2", line2_text, SPACES);

        // Directed test-plan cases against literal strings.
`ifdef LEADING_ZERO_BLANK_EN
        exp2 = "MONEY:  50      ";
`else
        exp2 = "MONEY:0050      ";
`endif
        run_txn("basic", 3, 1200, 50, 1'b0, "ITEM:3 P:1200   ", exp2, 7'h05);

`ifdef LEADING_ZERO_BLANK_EN
        exp1 = "ITEM:? P:   0   ";
`else
        exp1 = "ITEM:? P:0000   ";
`endif
        run_txn("ovf", 12, 0, 12000, 1'b0, exp1, "MONEY:----      ", 7'h05);

        run_txn("admin", 7, 250, 100, 1'b1, m_l1(7, 250), "ADMIN MODE      ", 7'h40);

        // Boundary values around MAX_VAL.
        run_model("max", 9, 9999, 10000, 1'b0);
        run_model("top", 0, 16383, 9999, 1'b0);

        // Coalesced updates: requests at cycles 5, 10, 29 yield exactly one re-run.
        set_inputs(4, 321, 40, 1'b0);
        exp1 = m_l1(4, 321);
        exp2 = m_l2(1'b0, 40);
        pulse_update();
        tv_cnt = 0;
        for (int k = 1; k <= 65; k++) begin
            update = (k == 5 || k == 10 || k == 29);
            if (k == 20) balance = BIN_W'(75);
            @(negedge clk);
            if (text_valid === 1'b1) tv_cnt++;
            if (k < 2 * LAT) chk("coal_busy", 128'(busy), 128'(1));
            if (k == LAT) begin
                chk("coal_tv1", 128'(text_valid), 128'(1));
                chk("coal_l2a", line2_text, exp2);
            end
            if (k == 2 * LAT) begin
                chk("coal_tv2", 128'(text_valid), 128'(1));
                chk("coal_l1b", line1_text, exp1);
                chk("coal_l2b", line2_text, m_l2(1'b0, 75));
                chk("coal_busy_end", 128'(busy), 128'(0));
            end
        end
        update = 1'b0;
        chk("coal_count", 128'(tv_cnt), 128'(2));

        // Reset mid-conversion aborts and clears outputs.
        run_model("preA", 2, 500, 600, 1'b0);
        set_inputs(8, 1234, 4321, 1'b0);
        pulse_update();
        for (int k = 1; k < 15; k++) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tv_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (text_valid !== 1'b0) tv_cnt++;
        end
        chk("abort_tv", 128'(tv_cnt), 128'(0));
        chk("abort_l1", line1_text, SPACES);
        chk("abort_l2", line2_text, SPACES);
        chk("abort_addr", 128'(ddram_address), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        run_model("postrst", 8, 1234, 4321, 1'b0);

        // Randomized transactions against the reference model.
        for (int n = 0; n < 8; n++) begin
            r_it  = int'($urandom_range(0, 15));
            r_pr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 9999));
            r_bl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 120));
            r_adm = ($urandom_range(0, 3) == 0);
            run_model("rand", r_it, r_pr, r_bl, r_adm);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
